// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Shared definitions for the LeNet result argmax block: default class count,
// score width, class index width and the accumulator state encoding.
// -----------------------------------------------------------------------------
package lenet_pkg;

  // Default number of class scores per frame.
  localparam int LENET_NUM_CLASS = 10;
  // Default signed score width in bits.
  localparam int LENET_SCORE_W   = 8;
  // Default class index width; 2**LENET_CLASS_W must cover LENET_NUM_CLASS.
  localparam int LENET_CLASS_W   = 4;

  // Accumulator FSM: ST_IDLE waits for the first score of a frame,
  // ST_ACC collects the remaining scores.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } lenet_state_e;

endpackage : lenet_pkg

// File: rtl/lenet_score_cmp.sv
// -----------------------------------------------------------------------------
// lenet_score_cmp
// Signed strict greater-than comparator with index select. The candidate wins
// only when it is strictly greater than the current best, so on equal scores
// the earlier (lower) index is kept.
//
// Ports:
//   cand_score  in   DW  candidate score (two's complement)
//   cand_idx    in   CW  candidate class index
//   best_score  in   DW  current best score (two's complement)
//   best_idx    in   CW  current best class index
//   cand_wins   out  1   candidate strictly greater than best
//   win_score   out  DW  score of the winner
//   win_idx     out  CW  index of the winner
// -----------------------------------------------------------------------------
module lenet_score_cmp
  import lenet_pkg::*;
#(
  parameter int DW = LENET_SCORE_W,
  parameter int CW = LENET_CLASS_W
) (
  input  logic [DW-1:0] cand_score,
  input  logic [CW-1:0] cand_idx,
  input  logic [DW-1:0] best_score,
  input  logic [CW-1:0] best_idx,
  output logic          cand_wins,
  output logic [DW-1:0] win_score,
  output logic [CW-1:0] win_idx
);

  // Signed strict comparison and winner selection.
  always_comb begin
    cand_wins = ($signed(cand_score) > $signed(best_score));
    if (cand_wins) begin
      win_score = cand_score;
      win_idx   = cand_idx;
    end else begin
      win_score = best_score;
      win_idx   = best_idx;
    end
  end

endmodule : lenet_score_cmp

// File: rtl/lenet_result_argmax.sv
// -----------------------------------------------------------------------------
// lenet_result_argmax
// Collects NUM_CLASS signed scores of one image from the accelerator result
// stream, selects the winning class (argmax, lowest index wins ties) and
// presents it to the host through a valid/ready result register. A completed
// frame that overwrites an undrained result raises the sticky overrun flag.
//
// Optional feature (macro LENET_SCORE_BUF_EN): keeps a bank with all scores of
// the last completed frame, readable through rd_addr/rd_score.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   out_now    in   1   score valid strobe, one score per high cycle
//   out_data   in   DW  score value (two's complement)
//   frame_clr  in   1   synchronous abort of a partial frame, clears overrun
//   res_ready  in   1   host accepts the result
//   res_valid  out  1   result register holds an unconsumed result
//   res_class  out  CW  argmax class index
//   res_score  out  DW  winning score
//   overrun    out  1   sticky, a result was overwritten before being drained
//   busy       out  1   a frame is partially collected
//   rd_addr    in   CW  (LENET_SCORE_BUF_EN) score bank read address
//   rd_score   out  DW  (LENET_SCORE_BUF_EN) score bank read data, 0 if out of range
// -----------------------------------------------------------------------------
module lenet_result_argmax
  import lenet_pkg::*;
#(
  parameter int NUM_CLASS = LENET_NUM_CLASS,
  parameter int DW        = LENET_SCORE_W,
  parameter int CW        = LENET_CLASS_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          out_now,
  input  logic [DW-1:0] out_data,
  input  logic          frame_clr,
  input  logic          res_ready,
  output logic          res_valid,
  output logic [CW-1:0] res_class,
  output logic [DW-1:0] res_score,
  output logic          overrun,
  output logic          busy
`ifdef LENET_SCORE_BUF_EN
  ,
  input  logic [CW-1:0] rd_addr,
  output logic [DW-1:0] rd_score
`endif
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASS - 1);
  localparam logic [CW-1:0] ONE_IDX  = CW'(1);

  // Accumulator state
  lenet_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] max_q, max_d;
  logic [CW-1:0] idx_q, idx_d;

  // Result register
  logic          res_valid_q, res_valid_d;
  logic [CW-1:0] res_class_q, res_class_d;
  logic [DW-1:0] res_score_q, res_score_d;
  logic          overrun_q, overrun_d;

  // Frame completion and the final (bypassed) winner
  logic          complete_s;
  logic [DW-1:0] fin_score_s;
  logic [CW-1:0] fin_idx_s;

  // Comparator outputs
  logic          cand_wins_s;
  logic [DW-1:0] win_score_s;
  logic [CW-1:0] win_idx_s;

  // The incoming score competes against the running max. The same result is
  // used both to update the running max and, on the last sample, as the
  // final winner so that the last score is included without an extra cycle.
  lenet_score_cmp #(
    .DW (DW),
    .CW (CW)
  ) u_cmp (
    .cand_score (out_data),
    .cand_idx   (cnt_q),
    .best_score (max_q),
    .best_idx   (idx_q),
    .cand_wins  (cand_wins_s),
    .win_score  (win_score_s),
    .win_idx    (win_idx_s)
  );

  // Accumulator next-state logic: frame counting, running max, completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    complete_s  = 1'b0;
    fin_score_s = max_q;
    fin_idx_s   = idx_q;

    if (frame_clr) begin
      // Abort wins over a same-cycle score.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (out_now) begin
      case (state_q)
        ST_IDLE: begin
          if (NUM_CLASS == 1) begin
            // Single-class frame completes on its only sample.
            complete_s  = 1'b1;
            fin_score_s = out_data;
            fin_idx_s   = '0;
          end else begin
            state_d = ST_ACC;
            cnt_d   = ONE_IDX;
            max_d   = out_data;
            idx_d   = '0;
          end
        end
        ST_ACC: begin
          if (cand_wins_s) begin
            max_d = out_data;
            idx_d = cnt_q;
          end else begin
            max_d = max_q;
            idx_d = idx_q;
          end
          if (cnt_q == LAST_IDX) begin
            complete_s  = 1'b1;
            fin_score_s = win_score_s;
            fin_idx_s   = win_idx_s;
            state_d     = ST_IDLE;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      // Gap in the stream: hold everything.
      state_d = state_q;
    end
  end

  // Result register next-state: load on completion, drop on handshake.
  always_comb begin
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    overrun_d   = overrun_q;

    if (complete_s) begin
      // A same-cycle handshake consumes the old result, so the new one
      // replaces it cleanly and stays valid.
      res_valid_d = 1'b1;
      res_class_d = fin_idx_s;
      res_score_d = fin_score_s;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    if (frame_clr) begin
      overrun_d = 1'b0;
    end else if (complete_s && res_valid_q && !res_ready) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_score = res_score_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == ST_ACC);

`ifdef LENET_SCORE_BUF_EN
  // Banks span the full index space so every CW-bit address is in range;
  // entries at or above NUM_CLASS are never written and stay zero.
  localparam int BANK_DEPTH = 1 << CW;

  logic [DW-1:0] shadow_q [BANK_DEPTH];
  logic [DW-1:0] shadow_d [BANK_DEPTH];
  logic [DW-1:0] bank_q   [BANK_DEPTH];
  logic [DW-1:0] bank_d   [BANK_DEPTH];

  // Shadow bank collects the partial frame; the visible bank is refreshed
  // on the completion edge, including the bypassed last score.
  always_comb begin
    shadow_d = shadow_q;
    bank_d   = bank_q;
    if (frame_clr) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        shadow_d[i] = '0;
      end
    end else if (out_now) begin
      // cnt_q is zero in ST_IDLE, so it addresses the first sample too.
      shadow_d[cnt_q] = out_data;
    end else begin
      shadow_d = shadow_q;
    end
    if (complete_s) begin
      bank_d = shadow_d;
    end else begin
      bank_d = bank_q;
    end
  end

  // Shadow and visible score banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
    end
  end

  // Combinational read, zero outside the class range.
  always_comb begin
    if (32'(rd_addr) < NUM_CLASS) begin
      rd_score = bank_q[rd_addr];
    end else begin
      rd_score = '0;
    end
  end
`endif

endmodule : lenet_result_argmax
